freq_code_detector: RTL and testbench
=====================================

FREQ_CODE_DETECTOR -- requirements
Module: freq_code_detector

Interface
REQ-001 Parameter GATE_CYCLES, default 65536, gives the measurement window length in clk cycles; legal range is 64..2^20.
REQ-002 Parameter BASE_EDGES, default 4, gives the nominal rising-edge count per window for code 3'b000; the nominal count for code k is BASE_EDGES<<k.
REQ-003 Port clk, input, 1 bit: clock; all state is updated on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port en, input, 1 bit: measurement enable, synchronous to clk.
REQ-006 Port sig_in, input, 1 bit: measured square wave, asynchronous to clk.
REQ-007 Port code_out, output, 3 bits: the decoded frequency code.
REQ-008 Port code_valid, output, 1 bit: asserted while code_out, no_match and edge_count hold an unconsumed result.
REQ-009 Port code_ready, input, 1 bit: consumer accepts the result.
REQ-010 Port no_match, output, 1 bit: the last result matched no code window.
REQ-011 Port overrun, output, 1 bit: sticky flag; a result was overwritten before it was accepted.
REQ-012 Port edge_count, output, 16 bits: raw rising-edge count of the last window.
REQ-013 Port locked, output, 1 bit: frequency-lock indication.

Function
REQ-014 sig_in SHALL pass through a 2-FF synchronizer and a rising-edge detector; the edge pulse appears 3 clk cycles after the sig_in transition.
REQ-015 FSM states SHALL be IDLE, MEASURE and EVAL.
- IDLE -> MEASURE when en=1.
- MEASURE -> EVAL after GATE_CYCLES cycles.
- EVAL -> MEASURE when en=1, otherwise EVAL -> IDLE.
REQ-016 In MEASURE, the gate counter SHALL count 0..GATE_CYCLES-1, and the edge counter SHALL increment once per edge pulse, saturating at 16'hFFFF.
REQ-017 EVAL SHALL last exactly 1 cycle, in which the result is registered and both counters are cleared; an edge pulse arriving in EVAL SHALL count toward the next window as its initial value 1.
REQ-018 Classification: code k matches when nom-(nom>>2) <= N <= nom+(nom>>2), with nom=BASE_EDGES<<k; the lowest matching k is selected. If no k matches, then no_match=1 and code_out=3'b000.
REQ-019 Arithmetic SHALL be unsigned at 20 bits, so that no intermediate overflows.
REQ-020 Result handshake: code_valid rises the cycle after EVAL and stays high until the cycle after code_valid&code_ready; the outputs are stable while code_valid=1.
REQ-021 A new result that arrives while code_valid=1 and code_ready=0 SHALL overwrite the outputs, keep code_valid=1, and set overrun=1; overrun clears only on reset.
REQ-022 If the new result arrives in the same cycle as the acceptance (ready=1), it SHALL be loaded, code_valid SHALL remain 1, and no overrun SHALL be flagged.
REQ-023 If en falls during MEASURE, the FSM SHALL go to IDLE next cycle, clear both counters, and produce no result; outputs already holding a result are kept.
REQ-024 Continuous operation SHALL produce results back to back, one every GATE_CYCLES+1 cycles.

Reset
REQ-025 On rst_n=0: state is IDLE; counters, synchronizer FFs, code_out, code_valid, no_match, overrun, edge_count and locked are 0.
REQ-026 Deasserting reset mid-window SHALL start from IDLE, and no partial result is produced.

Configuration
REQ-027 Macro FREQ_DET_LOCK_FILTER_EN defined: locked SHALL assert only after 2 consecutive matching results with identical code_out, and clear on the first no_match or code change.
REQ-028 Macro FREQ_DET_LOCK_FILTER_EN undefined: locked SHALL equal ~no_match of the last result, and 0 before the first result.

Structure
REQ-029 Package freq_det_pkg SHALL hold the FSM state enum, CODE_W=3, CNT_W=16, and a function nominal(k) returning BASE_EDGES<<k.
REQ-030 Sub-module sig_sync_edge SHALL implement the synchronizer and rising-edge detector; all other logic is in freq_code_detector.

Verification (GATE_CYCLES=4096, BASE_EDGES=4)
REQ-031 en=1 with sig_in period 128 clk (32 edges) -> code_out=3'b011, no_match=0, edge_count=32, code_valid 4097 cycles after start.
REQ-032 en=1 with sig_in period 8 clk (512 edges) -> code_out=3'b111; period 2048 clk (2 edges) -> no_match=1, code_out=3'b000.
REQ-033 Hold code_ready=0 across 2 windows -> second result visible, overrun=1, code_valid stays 1.
REQ-034 en dropped at gate cycle 2000 -> IDLE next cycle, no code_valid pulse, counters 0.
REQ-035 With FREQ_DET_LOCK_FILTER_EN, 3 windows at period 64 -> locked=0 after window 1 and 1 after window 2; switching to period 32 -> locked=0 on the next result.
REQ-036 rst_n pulsed low mid-window with code_valid=1 -> all outputs 0 asynchronously and the FSM is in IDLE.

Source files
------------

// File: rtl/freq_det_pkg.sv
// -----------------------------------------------------------------------------
// freq_det_pkg
// Shared types, widths and helpers for the frequency-code detector.
//   state_t    : measurement FSM states (IDLE, MEASURE, EVAL)
//   CODE_W     : width of the decoded frequency code
//   CNT_W      : width of the raw edge counter
//   ARITH_W    : width used for all classification arithmetic, wide enough
//                that nominal +/- tolerance never overflows
//   nominal()  : nominal edge count for a code, base_edges << k
//   in_window(): true when a count lies inside nom +/- nom/4 (inclusive)
// -----------------------------------------------------------------------------
package freq_det_pkg;

    localparam int CODE_W    = 3;
    localparam int CNT_W     = 16;
    localparam int ARITH_W   = 20;
    localparam int NUM_CODES = 1 << CODE_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_EVAL    = 2'd2
    } state_t;

    function automatic logic [ARITH_W-1:0] nominal(
        input logic [ARITH_W-1:0] base_edges,
        input logic [CODE_W-1:0]  k
    );
        return base_edges << k;
    endfunction

    function automatic logic in_window(
        input logic [ARITH_W-1:0] n,
        input logic [ARITH_W-1:0] nom
    );
        return (n >= (nom - (nom >> 2))) && (n <= (nom + (nom >> 2)));
    endfunction

endpackage

// File: rtl/freq_code_detector_sig_sync_edge.sv
// -----------------------------------------------------------------------------
// sig_sync_edge
// Brings the asynchronous square wave into the clk domain through a two-flop
// synchronizer and emits a one-cycle pulse per rising edge. The pulse is
// registered, so it is visible 3 clk cycles after the sig_in transition.
// Ports:
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   sig_in     : asynchronous square wave
//   edge_pulse : one-cycle pulse per synchronized rising edge
// -----------------------------------------------------------------------------
module sig_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic edge_pulse
);

    logic sync_meta;
    logic sync_q;
    logic sync_prev;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would collapse
    // the synchronizer chain into a single stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta  <= 1'b0;
            sync_q     <= 1'b0;
            sync_prev  <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            sync_meta  <= sig_in;
            sync_q     <= sync_meta;
            sync_prev  <= sync_q;
            edge_pulse <= sync_q & ~sync_prev;
        end
    end

endmodule

// File: rtl/freq_code_detector.sv
// -----------------------------------------------------------------------------
// freq_code_detector
// Counts rising edges of sig_in over a gate window of GATE_CYCLES clk cycles
// and classifies the count into a 3-bit code k whose nominal count is
// BASE_EDGES<<k (+/-25 %). Results are presented through a valid/ready
// handshake; an unaccepted result that is overwritten sets a sticky overrun.
//
// Parameters:
//   GATE_CYCLES : window length in clk cycles (64 .. 2^20)
//   BASE_EDGES  : nominal edge count for code 0
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : measurement enable (clk domain)
//   sig_in      : measured square wave (asynchronous)
//   code_out    : decoded code of the last result (0 when no_match)
//   code_valid  : result held and not yet accepted
//   code_ready  : consumer accepts the result
//   no_match    : last result matched no code window
//   overrun     : sticky, a result was overwritten before acceptance
//   edge_count  : raw edge count of the last window
//   locked      : frequency-lock indication
// Build option:
//   FREQ_DET_LOCK_FILTER_EN : when defined, locked requires two consecutive
//   matching results with the same code; otherwise locked = ~no_match of the
//   last result.
// -----------------------------------------------------------------------------
module freq_code_detector
    import freq_det_pkg::*;
#(
    parameter int GATE_CYCLES = 65536,
    parameter int BASE_EDGES  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sig_in,
    output logic [CODE_W-1:0] code_out,
    output logic              code_valid,
    input  logic              code_ready,
    output logic              no_match,
    output logic              overrun,
    output logic [CNT_W-1:0]  edge_count,
    output logic              locked
);

    localparam logic [ARITH_W-1:0] GATE_LAST = ARITH_W'(GATE_CYCLES - 1);
    localparam logic [ARITH_W-1:0] BASE_W    = ARITH_W'(BASE_EDGES);

    state_t               state_q;
    state_t               state_d;
    logic [ARITH_W-1:0]   gate_cnt;
    logic [CNT_W-1:0]     edge_cnt;
    logic                 edge_pulse;
    logic                 match_found;
    logic [CODE_W-1:0]    match_code;
    logic                 result_load;

    sig_sync_edge u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .sig_in     (sig_in),
        .edge_pulse (edge_pulse)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal driven here gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
                // Dropping en abandons the window without a result.
                if (!en)                         state_d = ST_IDLE;
                else if (gate_cnt == GATE_LAST)  state_d = ST_EVAL;
            end
            ST_EVAL: begin
                state_d = en ? ST_MEASURE : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ----------------------------------------------------------- counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
        end else begin
            case (state_q)
                ST_MEASURE: begin
                    if (!en) begin
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                    end else begin
                        gate_cnt <= (gate_cnt == GATE_LAST) ? '0 : gate_cnt + ARITH_W'(1);
                        if (edge_pulse && (edge_cnt != {CNT_W{1'b1}}))
                            edge_cnt <= edge_cnt + CNT_W'(1);
                    end
                end
                ST_EVAL: begin
                    // An edge landing in EVAL belongs to the next window, but
                    // only if a next window actually follows.
                    gate_cnt <= '0;
                    edge_cnt <= CNT_W'(edge_pulse && en);
                end
                default: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------ classification
    // Scan from the highest code down so the lowest matching code wins.
    always_comb begin
        match_found = 1'b0;
        match_code  = '0;
        for (int k = NUM_CODES - 1; k >= 0; k--) begin
            if (in_window(ARITH_W'(edge_cnt), nominal(BASE_W, CODE_W'(k)))) begin
                match_found = 1'b1;
                match_code  = CODE_W'(k);
            end
        end
    end

    assign result_load = (state_q == ST_EVAL);

    // ---------------------------------------------------- result handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_out   <= '0;
            no_match   <= 1'b0;
            edge_count <= '0;
            code_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (result_load) begin
            code_out   <= match_found ? match_code : '0;
            no_match   <= ~match_found;
            edge_count <= edge_cnt;
            code_valid <= 1'b1;
            // A result accepted in the same cycle is not lost.
            if (code_valid && !code_ready)
                overrun <= 1'b1;
        end else if (code_valid && code_ready) begin
            code_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------- locking
`ifdef FREQ_DET_LOCK_FILTER_EN
    logic              prev_match;
    logic [CODE_W-1:0] prev_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked     <= 1'b0;
            prev_match <= 1'b0;
            prev_code  <= '0;
        end else if (result_load) begin
            locked     <= match_found && prev_match && (match_code == prev_code);
            prev_match <= match_found;
            prev_code  <= match_code;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked <= 1'b0;
        end else if (result_load) begin
            locked <= match_found;
        end
    end
`endif

endmodule

// File: tb/tb_freq_code_detector.sv
// -----------------------------------------------------------------------------
// tb_freq_code_detector
// Drives directed and randomized sig_in / en / code_ready patterns into
// freq_code_detector (GATE_CYCLES=4096, BASE_EDGES=4) and compares its outputs
// every cycle against a window/time-stamp model of the detector, plus a set of
// hand-computed literal expectations. Honors FREQ_DET_LOCK_FILTER_EN.
// -----------------------------------------------------------------------------
module tb_freq_code_detector;
    import freq_det_pkg::*;

    localparam int G     = 4096;
    localparam int B     = 4;
    localparam int DEPTH = 131072;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        sig_in;
    logic [2:0]  code_out;
    logic        code_valid;
    logic        code_ready;
    logic        no_match;
    logic        overrun;
    logic [15:0] edge_count;
    logic        locked;

    int errors = 0;
    int checks = 0;
    int half_per = 0;

    freq_code_detector #(.GATE_CYCLES(G), .BASE_EDGES(B)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .sig_in     (sig_in),
        .code_out   (code_out),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .no_match   (no_match),
        .overrun    (overrun),
        .edge_count (edge_count),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Square-wave generator: toggles every half_per cycles, away from clk edges.
    initial begin
        int ph;
        ph = 0;
        sig_in = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            if (half_per > 0) begin
                ph++;
                if (ph >= half_per) begin
                    ph = 0;
                    sig_in = ~sig_in;
                end
            end
        end
    end

    // ------------------------------------------------------------- model
    // Time-stamped view: every sampled rising edge of sig_in is marked at the
    // cycle its pulse is consumed (sample cycle + 3). A window is described by
    // its start cycle; its count is the number of marks in its span.
    bit          pulse_at [0:DEPTH-1];
    int          cyc = 0;
    bit          prev_s;
    bit          win_open;
    bit          win_carry;
    int          win_start;
    bit          m_valid, m_nm, m_ovr, m_locked;
    logic [2:0]  m_code;
    logic [15:0] m_cnt;
    bit          lk_prev_match;
    int          lk_prev_code;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) if (cyc + i < DEPTH) pulse_at[cyc + i] = 1'b0;
            prev_s = 0; win_open = 0; win_carry = 0; win_start = 0;
            m_valid = 0; m_nm = 0; m_ovr = 0; m_locked = 0;
            m_code = '0; m_cnt = '0;
            lk_prev_match = 0; lk_prev_code = 0;
        end else begin
            bit result_now;
            int n, lo, code;
            bit found;
            if (sig_in && !prev_s) pulse_at[cyc + 3] = 1'b1;
            prev_s = sig_in;
            result_now = 0;
            n = 0;
            if (win_open) begin
                if (cyc <= win_start + G) begin
                    if (!en) win_open = 0;
                end else begin
                    result_now = 1;
                    lo = win_carry ? win_start : win_start + 1;
                    for (int t = lo; t <= win_start + G; t++) if (pulse_at[t]) n++;
                    if (n > 65535) n = 65535;
                    if (en) begin
                        win_start = cyc;
                        win_carry = 1;
                    end else begin
                        win_open = 0;
                    end
                end
            end else if (en) begin
                win_open  = 1;
                win_start = cyc;
                win_carry = 0;
            end

            if (result_now) begin
                found = 0;
                code  = 0;
                for (int k = 0; k < 8; k++) begin
                    int nom, tol;
                    nom = B * (1 << k);
                    tol = nom / 4;
                    if (!found && n >= nom - tol && n <= nom + tol) begin
                        found = 1;
                        code  = k;
                    end
                end
                if (m_valid && !code_ready) m_ovr = 1;
                m_valid = 1;
                m_nm    = !found;
                m_code  = 3'(code);
                m_cnt   = 16'(n);
`ifdef FREQ_DET_LOCK_FILTER_EN
                m_locked = found && lk_prev_match && (code == lk_prev_code);
`else
                m_locked = found;
`endif
                lk_prev_match = found;
                lk_prev_code  = code;
            end else if (m_valid && code_ready) begin
                m_valid = 0;
            end
            cyc++;
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (rst_n)
            check("outputs{valid,nm,ovr,lock,code,cnt}",
                  {code_valid, no_match, overrun, locked, code_out, edge_count},
                  {m_valid, m_nm, m_ovr, m_locked, m_code, m_cnt});
    end

    task automatic wait_valid(input string name, input int max_cyc, output int n);
        bit ok;
        n  = 0;
        ok = 0;
        while (n < max_cyc && !ok) begin
            @(negedge clk);
            n++;
            if (code_valid) ok = 1;
        end
        check({name, "_valid_seen"}, ok, 1);
    endtask

    initial begin
        #(95000 * 10);
        $display("FAIL watchdog: simulation did not finish within the cycle budget");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        int n, seen;
        logic [3:0] lock_exp;
        rst_n = 1'b0;
        en = 1'b0;
        code_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {code_valid, no_match, overrun, locked, code_out, edge_count}, 0);
        check("rst_state", dut.state_q, ST_IDLE);
        rst_n = 1'b1;

        // A: period 128 -> 32 edges, code 3, result G+1 cycles after start.
        half_per = 64;
        repeat (300) @(negedge clk);
        code_ready = 1'b1;
        en = 1'b1;
        wait_valid("a", G + 100, n);
        check("a_latency", n - 1, G + 1);
        check("a_code", code_out, 3);
        check("a_no_match", no_match, 0);
        check("a_edge_count", edge_count, 32);
`ifdef FREQ_DET_LOCK_FILTER_EN
        check("a_locked", locked, 0);
`else
        check("a_locked", locked, 1);
`endif
        en = 1'b0;

        // B: period 8 -> 512 edges, code 7; period 2048 -> 2 edges, no match.
        half_per = 4;
        repeat (20) @(negedge clk);
        en = 1'b1;
        wait_valid("b7", G + 100, n);
        check("b7_code", code_out, 7);
        check("b7_edge_count", edge_count, 512);
        en = 1'b0;
        half_per = 1024;
        repeat (100) @(negedge clk);
        en = 1'b1;
        wait_valid("bnm", G + 100, n);
        check("bnm_no_match", no_match, 1);
        check("bnm_code", code_out, 0);
        check("bnm_edge_count", edge_count, 2);
        check("bnm_locked", locked, 0);
        en = 1'b0;

        // New result arriving in the acceptance cycle: loaded, no overrun.
        half_per = 64;
        code_ready = 1'b0;
        repeat (100) @(negedge clk);
        en = 1'b1;
        wait_valid("s", G + 100, n);
        repeat (G) @(negedge clk);
        code_ready = 1'b1;
        @(negedge clk);
        check("s_valid_kept", code_valid, 1);
        check("s_no_overrun", overrun, 0);
        check("s_code", code_out, 3);
        en = 1'b0;
        @(negedge clk);
        check("s_accepted", code_valid, 0);

        // D: en dropped at gate cycle 2000 -> IDLE, counters cleared, no result.
        repeat (100) @(negedge clk);
        en = 1'b1;
        repeat (2001) @(negedge clk);
        check("d_gate_at_drop", dut.gate_cnt, 2000);
        en = 1'b0;
        @(negedge clk);
        check("d_state", dut.state_q, ST_IDLE);
        check("d_gate_cnt", dut.gate_cnt, 0);
        check("d_edge_cnt", dut.edge_cnt, 0);
        seen = 0;
        repeat (2500) begin
            @(negedge clk);
            if (code_valid) seen++;
        end
        check("d_no_result", seen, 0);

        // E: lock behaviour, three windows at period 64 then period 32.
`ifdef FREQ_DET_LOCK_FILTER_EN
        lock_exp = 4'b0110;
`else
        lock_exp = 4'b1111;
`endif
        half_per = 32;
        repeat (100) @(negedge clk);
        en = 1'b1;
        for (int w = 0; w < 3; w++) begin
            wait_valid("e", G + 100, n);
            check("e_code64", code_out, 4);
            check("e_locked", locked, lock_exp[w]);
        end
        half_per = 16;
        wait_valid("e4", G + 100, n);
        check("e_code128", code_out, 5);
        check("e_locked_change", locked, lock_exp[3]);
        en = 1'b0;

        // C: two windows with no acceptance -> overwrite, sticky overrun.
        half_per = 64;
        code_ready = 1'b0;
        repeat (100) @(negedge clk);
        en = 1'b1;
        wait_valid("c", G + 100, n);
        repeat (G + 1) @(negedge clk);
        check("c_valid", code_valid, 1);
        check("c_overrun", overrun, 1);
        check("c_code", code_out, 3);

        // F: randomized frequency, ready and occasional en drops.
        for (int i = 0; i < 3 * (G + 1); i++) begin
            @(negedge clk);
            code_ready = 1'($urandom_range(0, 1));
            en = ($urandom_range(0, 1999) != 0);
            if (i % 1400 == 0) half_per = $urandom_range(1, 1100);
        end
        en = 1'b0;
        code_ready = 1'b1;
        repeat (5) @(negedge clk);

        // G: asynchronous reset mid-window with a result pending.
        code_ready = 1'b0;
        half_per = 64;
        repeat (100) @(negedge clk);
        en = 1'b1;
        wait_valid("g", G + 100, n);
        repeat (1000) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("g_async_outputs", {code_valid, no_match, overrun, locked, code_out, edge_count}, 0);
        check("g_state", dut.state_q, ST_IDLE);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_valid("g_after", G + 100, n);
        check("g_latency", n - 1, G + 1);
        check("g_code", code_out, 3);
        check("g_overrun_cleared", overrun, 0);
`ifdef FREQ_DET_LOCK_FILTER_EN
        check("g_locked", locked, 0);
`else
        check("g_locked", locked, 1);
`endif
        en = 1'b0;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
